// File: rtl/vending_machine_if.sv
// Coin-acceptor / actuator signal bundle for the vending controller.
// The master side drives coin pulses; the slave side (the controller) drives the command pulses.
interface vending_machine_if;
  logic quarter;
  logic dollar;
  logic dispense;
  logic change;

  modport master (output quarter, output dollar, input dispense, input change);
  modport slave  (input quarter, input dollar, output dispense, output change);
endinterface

// File: rtl/vending_machine.sv
// Single-item vending controller: accumulates quarter/dollar credit and vends at PRICE_Q.
// Excess credit is returned with a single change pulse in the vend cycle.
//
// state      | meaning (credit value, PRICE_Q=3)
// IDLE  (0)  | no credit held
// C25   (1)  | 25 cents held
// C50   (2)  | 50 cents held
module vending_machine #(
  parameter int PRICE_Q  = 3,
  parameter int DOLLAR_Q = 4
) (
  input logic              clk,
  input logic              rstn,
  vending_machine_if.slave bus
);

  // Wide enough for the largest possible sum: (PRICE_Q-1) + 1 + DOLLAR_Q.
  localparam int CW = $clog2(PRICE_Q + DOLLAR_Q + 1);

  localparam logic [CW-1:0] IDLE     = '0;
  localparam logic [CW-1:0] PRICE_V  = CW'(PRICE_Q);
  localparam logic [CW-1:0] DOLLAR_V = CW'(DOLLAR_Q);

  logic [CW-1:0] credit;
  logic [CW-1:0] sum;

  always_comb begin
    sum = credit + CW'(bus.quarter) + (bus.dollar ? DOLLAR_V : '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit       <= IDLE;
      bus.dispense <= 1'b0;
      bus.change   <= 1'b0;
    end else if (sum >= PRICE_V) begin
      credit       <= IDLE;
      bus.dispense <= 1'b1;
      bus.change   <= (sum > PRICE_V);
    end else begin
      credit       <= sum;
      bus.dispense <= 1'b0;
      bus.change   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: hand-computed dispense/change/credit after each coin cycle.
module tb_vending_machine;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  vending_machine_if bus ();

  vending_machine #(.PRICE_Q(3), .DOLLAR_Q(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents coins for one posedge, returns at the following negedge.
  task automatic coin(input logic q, input logic d);
    bus.quarter = q;
    bus.dollar  = d;
    @(negedge clk);
    bus.quarter = 1'b0;
    bus.dollar  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int disp, input int chg, input int cr);
    check({tag, ".dispense"}, int'(bus.dispense), disp);
    check({tag, ".change"},   int'(bus.change),   chg);
    check({tag, ".credit"},   int'(dut.credit),   cr);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rstn        = 1'b0;
    bus.quarter = 1'b0;
    bus.dollar  = 1'b0;
    #1;
    expect_out("reset", 0, 0, 0);
    @(negedge clk);

    // 1: coins ignored during reset
    coin(0, 1); expect_out("t1.dollar_in_reset", 0, 0, 0);
    coin(1, 0); expect_out("t1.quarter_in_reset", 0, 0, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 2: dollar vends with change, pulse lasts one cycle
    coin(0, 1); expect_out("t2.dollar", 1, 1, 0);
    coin(0, 0); expect_out("t2.after", 0, 0, 0);

    // 3: three quarters, exact price
    coin(1, 0); expect_out("t3.q1", 0, 0, 1);
    coin(1, 0); expect_out("t3.q2", 0, 0, 2);
    coin(1, 0); expect_out("t3.q3", 1, 0, 0);
    coin(0, 0); expect_out("t3.after", 0, 0, 0);

    // 4: two quarters then a dollar, next quarter starts fresh
    coin(1, 0); expect_out("t4.q1", 0, 0, 1);
    coin(1, 0); expect_out("t4.q2", 0, 0, 2);
    coin(0, 1); expect_out("t4.dollar", 1, 1, 0);
    coin(1, 0); expect_out("t4.q_next", 0, 0, 1);
    coin(1, 0); expect_out("t4.q_next2", 0, 0, 2);
    coin(1, 0); expect_out("t4.q_next3", 1, 0, 0);

    // 5: credit held across idle cycles
    coin(1, 0); expect_out("t5.q1", 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      coin(0, 0); expect_out($sformatf("t5.idle%0d", i), 0, 0, 1);
    end
    coin(1, 0); expect_out("t5.q2", 0, 0, 2);
    coin(1, 0); expect_out("t5.q3", 1, 0, 0);

    // simultaneous coins and dollar from partial credit
    coin(1, 1); expect_out("both.idle", 1, 1, 0);
    coin(1, 0); expect_out("c25.q", 0, 0, 1);
    coin(0, 1); expect_out("c25.dollar", 1, 1, 0);
    coin(1, 0); coin(1, 0); expect_out("c50.setup", 0, 0, 2);
    coin(1, 1); expect_out("both.c50", 1, 1, 0);
    coin(0, 0); expect_out("both.after", 0, 0, 0);

    // 6: async reset between edges while in C50
    coin(1, 0); coin(1, 0); expect_out("t6.setup", 0, 0, 2);
    #2 rstn = 1'b0;
    #1 expect_out("t6.async", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    coin(1, 0); expect_out("t6.q1", 0, 0, 1);
    coin(1, 0); expect_out("t6.q2", 0, 0, 2);
    coin(1, 0); expect_out("t6.q3", 1, 0, 0);

    // async reset clears a live dispense/change pulse immediately
    coin(0, 1); expect_out("rst_pulse.setup", 1, 1, 0);
    #2 rstn = 1'b0;
    #1 expect_out("rst_pulse.async", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    coin(0, 0); expect_out("rst_pulse.after", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
